// File: rtl/data_bus_if_if.sv
// Signal bundle between the MEM stage, the data-side bus interface and the Wishbone slave.
// Suffixes are from the bus interface's point of view (master modport).
interface data_bus_if_if;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        stallreq_o;
    logic        stall_i;
    logic        flush_i;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    modport master (
        input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_wdata_i,
        input  stall_i, flush_i, bus_dat_i, bus_ack_i,
        output cpu_rdata_o, stallreq_o,
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_dat_o, bus_err_o
    );

    modport slave (
        output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_wdata_i,
        output stall_i, flush_i, bus_dat_i, bus_ack_i,
        input  cpu_rdata_o, stallreq_o,
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_dat_o, bus_err_o
    );
endinterface

// File: rtl/data_bus_if.sv
// Data-side bus interface: turns the MEM stage's combinational request into a registered
// Wishbone-classic transaction, stalling the pipeline until ack or timeout.
module data_bus_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    data_bus_if_if.master  bus
);

    localparam int unsigned CntW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic              cyc_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        sel_q;
    logic [31:0]       dat_q;
    logic [31:0]       rbuf_q;
    logic [CntW-1:0]   cnt_q;

    logic start_c;
    logic timeout_c;
    logic done_c;

    // A timeout only counts when the slave did not ack in the same cycle.
    always_comb begin
        start_c   = (state_q == IDLE) && bus.cpu_ce_i && !bus.flush_i;
        timeout_c = (state_q == BUSY) && !bus.bus_ack_i && (cnt_q == CntW'(TIMEOUT_CYCLES));
        done_c    = (state_q == BUSY) && (bus.bus_ack_i || timeout_c);
    end

    // Pipeline-facing signals must react in the request/ack cycle itself.
    always_comb begin
        bus.stallreq_o  = 1'b0;
        bus.cpu_rdata_o = 32'h0;
        bus.bus_err_o   = 1'b0;
        case (state_q)
            IDLE: bus.stallreq_o = bus.cpu_ce_i;
            BUSY: begin
                if (bus.bus_ack_i) begin
                    bus.cpu_rdata_o = bus.bus_dat_i;
                end else if (timeout_c) begin
                    bus.bus_err_o = 1'b1;
                end else begin
                    bus.stallreq_o = 1'b1;
                end
            end
            HOLD:    bus.cpu_rdata_o = rbuf_q;
            default: bus.cpu_rdata_o = 32'h0;
        endcase
        if (bus.flush_i) begin
            bus.stallreq_o = 1'b0;
            bus.bus_err_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            sel_q   <= 4'h0;
            dat_q   <= 32'h0;
            rbuf_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        addr_q  <= bus.cpu_addr_i;
                        sel_q   <= bus.cpu_sel_i;
                        we_q    <= bus.cpu_we_i;
                        dat_q   <= bus.cpu_we_i ? bus.cpu_wdata_i : 32'h0;
                        cyc_q   <= 1'b1;
                        cnt_q   <= CntW'(1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (done_c) begin
                        rbuf_q  <= bus.bus_ack_i ? bus.bus_dat_i : 32'h0;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= bus.stall_i ? HOLD : IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                HOLD: begin
                    if (bus.flush_i || !bus.stall_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bus_cyc_o  = cyc_q;
    assign bus.bus_stb_o  = cyc_q;
    assign bus.bus_we_o   = we_q;
    assign bus.bus_addr_o = addr_q;
    assign bus.bus_sel_o  = sel_q;
    assign bus.bus_dat_o  = dat_q;

endmodule

// File: doc/data_bus_if.md
# data_bus_if

Data-side bus interface for the five-stage MIPS core; sits directly downstream of the MEM stage and consumes its memory request (ce, we, addr, sel, wdata). It turns that single-cycle combinational request into a registered Wishbone-classic transaction. It returns read data to MEM and holds the pipeline through `stallreq_o` until the slave acknowledges. A cycle timeout guards against a hung slave.

## Interface
- `TIMEOUT_CYCLES`, 255: BUSY cycles without ack before forced termination; range 1..65535.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_ce_i`  in  1  request valid from MEM stage.
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address.
- `cpu_sel_i`  in  4  byte lane enables.
- `cpu_wdata_i`  in  32  store data.
- `cpu_rdata_o`  out  32  load data to MEM stage.
- `stallreq_o`  out  1  stall request to pipeline control.
- `stall_i`  in  1  MEM stage held by pipeline control for any reason.
- `flush_i`  in  1  pipeline flush (exception); kills the current access.
- `bus_cyc_o`, `bus_stb_o`  out  1  Wishbone cycle/strobe.
- `bus_we_o`  out  1  write enable.
- `bus_addr_o`  out  32  address.
- `bus_sel_o`  out  4  byte select.
- `bus_dat_o`  out  32  write data.
- `bus_dat_i`  in  32  read data.
- `bus_ack_i`  in  1  slave acknowledge.
- `bus_err_o`  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, BUSY, HOLD. Reset → IDLE.
- Reset values: all `bus_*_o` outputs 0, `cpu_rdata_o` 0, `stallreq_o` 0, `bus_err_o` 0, read buffer 0, timeout counter 0.
- IDLE:
  - If `cpu_ce_i && !flush_i`: `stallreq_o`=1 combinationally.
  - At the edge: register `bus_addr_o`=addr, `bus_sel_o`=sel, `bus_we_o`=we, `bus_dat_o`=we ? wdata : 0, `cyc`=`stb`=1, counter=1; go to BUSY.
  - `cpu_rdata_o`=0.
- BUSY, `bus_ack_i`=1:
  - `stallreq_o`=0 and `cpu_rdata_o`=`bus_dat_i` (combinational pass-through).
  - Read buffer latches `bus_dat_i`; `cyc`/`stb`/`we` clear at the edge.
  - Next state is HOLD if `stall_i`=1, else IDLE.
- BUSY, no ack:
  - `stallreq_o`=1 and `cpu_rdata_o`=0; counter increments.
  - When counter == `TIMEOUT_CYCLES`, that cycle acts as an ack with data 0 and `bus_err_o`=1.
- HOLD:
  - `stallreq_o`=0 and `cpu_rdata_o`=read buffer; no new transaction is issued even though the same request is still presented.
  - Returns to IDLE on the first cycle with `stall_i`=0.
- `flush_i`=1 in any state:
  - `stallreq_o`=0 that cycle.
  - Next edge: `cyc`/`stb`/`we` cleared, state → IDLE, read buffer unchanged, no `bus_err_o`.
  - A store already acknowledged is not undone.
- `bus_ack_i` is ignored outside BUSY.
- Bus outputs are registered, never combinational from `cpu_*`.

## Timing
- Request seen at cycle T (IDLE) → `stallreq_o`=1 at T; `cyc`/`stb` high from T+1.
- Zero-wait slave (ack at T+1) → data valid and stall released at T+1; the pipeline advances at the end of T+1. Minimum access is 2 cycles.
- N wait states → ack at T+1+N; `stallreq_o` high for cycles T..T+N.
- Back-to-back: a new request at T+2 starts without a bubble cycle.
- Timeout: with no ack, `bus_err_o` pulses at T+`TIMEOUT_CYCLES`; stall is released in the same cycle.
- Simultaneous events:
  - ack together with timeout: ack wins, no error.
  - flush together with ack: flush wins; state → IDLE, not HOLD.
  - rst mid-BUSY: bus released next edge, all outputs return to reset values.

## Test plan
- Load, zero-wait slave: addr 0x100, sel 1111, slave returns 0xDEADBEEF at T+1 → `stallreq_o` high T only; `cpu_rdata_o`=0xDEADBEEF at T+1; `cyc` low at T+2.
- Store, 3 wait states: addr 0x204, sel 0011, wdata 0x12345678 → `bus_we_o`=1 and `bus_dat_o`=0x12345678 T+1..T+4; `stallreq_o` high T..T+3; exactly one write to the slave model.
- Ack while `stall_i`=1 for 4 more cycles: slave returns 0xA5A5A5A5 → HOLD for 4 cycles with `cpu_rdata_o`=0xA5A5A5A5, no second `stb`, then IDLE.
- Timeout with `TIMEOUT_CYCLES`=4 and a slave that never acks → `bus_err_o` pulses at T+4; `cpu_rdata_o`=0; `stallreq_o` low at T+4; `cyc` low at T+5.
- Flush at T+2 during a load with a 5-wait-state slave → `stallreq_o` low at T+2; `cyc` low at T+3; a later ack is ignored; the next request proceeds normally.
- `rst` asserted while BUSY → all outputs 0 at the next edge; state IDLE; a subsequent load completes correctly.
